alu_exec_unit: RTL and testbench

Parametrised, handshaked execute unit; the successor of the single-cycle ALU control decoder. It decodes ALUOp/func7/func3 internally and executes base integer ops with one-cycle registered latency. It adds iterative multiply/divide/remainder (func7 = 0000001), taking XLEN+1 cycles. It sits between register read and writeback and stalls the pipeline through a valid/ready handshake.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_decode.sv | 39 +++
 rtl/alu_exec_unit.sv | 152 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op, ALUOp, func7 and FSM state definitions for the execute unit.
package alu_pkg;
   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
      OP_OR, OP_AND, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
   } alu_op_e;
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [6:0] F7_BASE     = 7'b0000000;
   localparam logic [6:0] F7_ALT      = 7'b0100000;
   localparam logic [6:0] F7_MULDIV   = 7'b0000001;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: maps ALUOp/func7/func3 to the internal op, flagging undecodable combinations.
module alu_decode
   import alu_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [1:0] alu_op,
   input  logic [6:0] func7,
   input  logic [2:0] func3,
   output alu_op_e    op
);
   always_comb begin
      op = OP_ILL;
      if (!alu_op[1])
         op = (alu_op == ALUOP_SUB) ? OP_SUB : OP_ADD;
      else if (func7 == F7_BASE)
         case (func3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
         endcase
      else if (func7 == F7_ALT)
         op = (func3 == 3'b000) ? OP_SUB : (func3 == 3'b101) ? OP_SRA : OP_ILL;
      else if (func7 == F7_MULDIV && ENABLE_M)
         case (func3)
            3'b000:  op = OP_MUL;
            3'b100:  op = OP_DIV;
            3'b101:  op = OP_DIVU;
            3'b110:  op = OP_REM;
            3'b111:  op = OP_REMU;
            default: op = OP_ILL;
         endcase
   end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked execute unit; single-cycle base ops, iterative mul/div/rem.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [6:0]      func7,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;

   alu_op_e         dec_op, op_q, op_d;
   state_e          state_q, state_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d, base_res, fin_res;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            qneg_q, qneg_d, rneg_q, rneg_d, bz_q, bz_d, zero_q, zero_d, illegal_q, illegal_d;
   logic            accept, is_m, sgn;
   logic [XLEN:0]   rem_sh, rem_sub;
   logic [SW-1:0]   sh;

   alu_decode #(.ENABLE_M(ENABLE_M)) u_dec (
      .alu_op(alu_op),
      .func7 (func7),
      .func3 (func3),
      .op    (dec_op)
   );

   assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;
   assign accept    = in_valid && in_ready;
   assign is_m      = dec_op inside {OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   assign sgn       = dec_op inside {OP_DIV, OP_REM};
   assign sh        = op_b[SW-1:0];
   assign rem_sh    = {acc_q, a_q[XLEN-1]};
   assign rem_sub   = rem_sh - {1'b0, b_q};
   // a_q doubles as multiplier and quotient, acc_q as product and partial remainder
   assign fin_res   = (op_q == OP_MUL) ? acc_q :
                      (op_q inside {OP_DIV, OP_DIVU}) ? (bz_q ? '1 : (qneg_q ? -a_q : a_q)) :
                      (rneg_q ? -acc_q : acc_q);

   always_comb begin
      base_res = '0;
      case (dec_op)
         OP_ADD:  base_res = op_a + op_b;
         OP_SUB:  base_res = op_a - op_b;
         OP_SLL:  base_res = op_a << sh;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         OP_XOR:  base_res = op_a ^ op_b;
         OP_SRL:  base_res = op_a >> sh;
         OP_SRA:  base_res = $signed(op_a) >>> sh;
         OP_OR:   base_res = op_a | op_b;
         OP_AND:  base_res = op_a & op_b;
         default: base_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      bz_d      = bz_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      if (accept && is_m) begin
         state_d = S_CALC;
         op_d    = dec_op;
         cnt_d   = CW'(XLEN);
         acc_d   = '0;
         a_d     = (sgn && op_a[XLEN-1]) ? -op_a : op_a;
         b_d     = (sgn && op_b[XLEN-1]) ? -op_b : op_b;
         qneg_d  = sgn && (op_a[XLEN-1] ^ op_b[XLEN-1]);
         rneg_d  = sgn && op_a[XLEN-1];
         bz_d    = (op_b == '0);
      end else if (accept) begin
         state_d   = S_DONE;
         result_d  = base_res;
         zero_d    = (base_res == '0);
         illegal_d = (dec_op == OP_ILL);
      end else if (state_q == S_DONE && out_ready) begin
         state_d = S_IDLE;
      end else if (state_q == S_CALC && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (op_q == OP_MUL) begin
            acc_d = a_q[0] ? acc_q + b_q : acc_q;
            a_d   = a_q >> 1;
            b_d   = b_q << 1;
         end else begin
            acc_d = rem_sub[XLEN] ? rem_sh[XLEN-1:0] : rem_sub[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], ~rem_sub[XLEN]};
         end
      end else if (state_q == S_CALC) begin
         state_d   = S_DONE;
         result_d  = fin_res;
         zero_d    = (fin_res == '0);
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_q      <= OP_ADD;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         bz_q      <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         bz_q      <= bz_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; expected results queued on accept, compared on output transfer.
module tb_alu_exec_unit;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_valid2, out_ready;
   logic        in_ready, out_valid, zero, illegal;
   logic        in_ready2, out_valid2, zero2, illegal2;
   logic [1:0]  alu_op;
   logic [6:0]  func7;
   logic [2:0]  func3;
   logic [31:0] op_a, op_b, result, result2;
   int          checks = 0, errors = 0, cyc = 0;

   typedef struct {logic [31:0] res; logic ill;} exp_t;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
   );

   alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .alu_op(alu_op), .func7(func7), .func3(func3), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid2), .out_ready(1'b1), .result(result2), .zero(zero2), .illegal(illegal2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, want);
      end
   endtask

   function automatic exp_t model(input logic [1:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb_;
      logic ovf;
      exp_t r;
      sa = a; sb_ = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r.res = 32'h0; r.ill = 1'b0;
      if (!ao[1]) r.res = ao[0] ? a - b : a + b;
      else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
         case (f3)
            3'd0: r.res = f7[5] ? a - b : a + b;
            3'd1: r.res = a << b[4:0];
            3'd2: r.res = {31'b0, sa < sb_};
            3'd3: r.res = {31'b0, a < b};
            3'd4: r.res = a ^ b;
            3'd5: r.res = f7[5] ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: r.res = a | b;
            default: r.res = a & b;
         endcase
      else if (f7 == 7'h01 && f3 == 3'd0) r.res = a * b;
      else if (f7 == 7'h01 && f3 == 3'd4) r.res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb_);
      else if (f7 == 7'h01 && f3 == 3'd5) r.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      else if (f7 == 7'h01 && f3 == 3'd6) r.res = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb_);
      else if (f7 == 7'h01 && f3 == 3'd7) r.res = (b == 0) ? a : a % b;
      else r.ill = 1'b1;
      return r;
   endfunction

   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("sb_result", result, e.res);
            check("sb_illegal", {31'b0, illegal}, {31'b0, e.ill});
            check("sb_zero", {31'b0, zero}, {31'b0, e.res == 32'h0});
         end
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
      logic acc;
      int n;
      alu_op = ao; func7 = f7; func3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end while (!acc && n < 100);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      else sb.push_back(model(ao, f7, f3, a, b));
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [31:0] want);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 100);
      check(tag, result, want);
   endtask

   task automatic run(input string tag, input logic [1:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
      step();
      send(ao, f7, f3, a, b);
      wait_out(tag, want);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 32'd0);
   endtask

   initial begin
      int c0, seen;
      rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
      alu_op = 2'b00; func7 = 7'h00; func3 = 3'd0; op_a = 32'h0; op_b = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'b0, zero}, 32'd0);
      check("rst_illegal", {31'b0, illegal}, 32'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'b0, in_ready}, 32'd1);

      step();
      alu_op = 2'b10; func7 = 7'h01; func3 = 3'd0; op_a = 32'd3; op_b = 32'd5; in_valid2 = 1'b1;
      step();
      in_valid2 = 1'b0;
      @(negedge clk);
      check("nom_valid", {31'b0, out_valid2}, 32'd1);
      check("nom_illegal", {31'b0, illegal2}, 32'd1);
      check("nom_result", result2, 32'd0);

      step();
      send(2'b00, 7'h00, 3'd0, 32'd5, 32'd7);
      @(negedge clk);
      check("add_valid", {31'b0, out_valid}, 32'd1);
      check("add_result", result, 32'd12);
      check("add_zero", {31'b0, zero}, 32'd0);

      run("sra", 2'b10, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000);
      run("slt", 2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1);

      step();
      send(2'b10, 7'h01, 3'd0, 32'h0000_FFFF, 32'h0001_0001);
      seen = 0;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         if (in_ready || out_valid) seen++;
      end
      check("calc_busy", seen, 32'd0);
      @(negedge clk);
      check("mul_valid", {31'b0, out_valid}, 32'd1);
      check("mul_result", result, 32'hFFFF_FFFF);

      run("div", 2'b10, 7'h01, 3'd4, -32'sd7, 32'd2, -32'sd3);
      run("rem", 2'b10, 7'h01, 3'd6, -32'sd7, 32'd2, -32'sd1);
      run("div0", 2'b10, 7'h01, 3'd4, 32'd123, 32'd0, 32'hFFFF_FFFF);
      run("rem0", 2'b11, 7'h01, 3'd6, -32'sd9, 32'd0, -32'sd9);
      run("div_ovf", 2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run("rem_ovf", 2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run("divu", 2'b10, 7'h01, 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
      run("m_ill", 2'b10, 7'h01, 3'd2, 32'd4, 32'd2, 32'd0);
      check("m_ill_flag", {31'b0, illegal}, 32'd1);
      run("sub", 2'b01, 7'h55, 3'd3, 32'd9, 32'd9, 32'd0);
      check("sub_zero", {31'b0, zero}, 32'd1);

      drain();
      step();
      out_ready = 1'b0;
      send(2'b00, 7'h00, 3'd0, 32'd3, 32'd4);
      op_a = 32'd99;
      @(negedge clk);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!out_valid || result != 32'd7) seen++;
      end
      check("hold_stable", seen, 32'd0);
      check("hold_ready", {31'b0, in_ready}, 32'd0);
      step();
      out_ready = 1'b1;
      drain();

      step();
      c0 = cyc;
      for (int i = 0; i < 4; i++) send(2'b00, 7'h00, 3'd0, 32'd100 * i, 32'd1);
      check("stream_cycles", cyc - c0, 32'd4);
      drain();

      for (int i = 0; i < 30; i++) begin
         logic [6:0] f7;
         f7 = (i % 3 == 0) ? 7'h00 : (i % 3 == 1) ? 7'h20 : 7'h01;
         step();
         send(2'($urandom_range(0, 3)), f7, 3'($urandom_range(0, 7)), $urandom, (i % 7 == 0) ? 32'd0 : $urandom);
      end
      drain();

      step();
      send(2'b10, 7'h01, 3'd4, 32'd100, 32'd7);
      repeat (5) step();
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check("abort_valid", {31'b0, out_valid}, 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_illegal", {31'b0, illegal}, 32'd0);
      check("abort_ready", {31'b0, in_ready}, 32'd1);
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_out", seen, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
